program_loader: RTL and testbench
=================================

PROGRAM_LOADER -- requirements
Module: Program_Loader

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, giving the instruction-memory word-address width (DEPTH = 2**ADDR_WIDTH words).
REQ-002 SHALL have parameter RST_HOLD, default 4, giving the cycles pe_rst stays high after a successful load.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port s_valid  input  1  the host presents an instruction word.
REQ-006 SHALL have port s_data  input  32  instruction word, RISC-V 32-bit format.
REQ-007 SHALL have port s_last  input  1  marks the final program word, or the checksum word when checksum is enabled.
REQ-008 SHALL have port s_ready  output  1  the loader accepts a word this cycle.
REQ-009 SHALL have port reload  input  1  single-cycle request to start a new load.
REQ-010 SHALL have port imem_we  output  1  instruction-memory write enable.
REQ-011 SHALL have port imem_addr  output  32  byte address, equal to word index times 4.
REQ-012 SHALL have port imem_wd  output  32  write data.
REQ-013 SHALL have port pe_rst  output  1  reset driven to the processing element.
REQ-014 SHALL have port words_loaded  output  ADDR_WIDTH+1  count of program words written.
REQ-015 SHALL have port done  output  1  a load completed and the processing element is running.
REQ-016 SHALL have port error  output  1  the load failed (overflow or checksum mismatch).

Function
REQ-017 SHALL implement the states IDLE, LOAD, HOLD, RUN and ERR.
REQ-018 SHALL count a transfer only when s_valid and s_ready are both high on a rising clk edge.
REQ-019 SHALL drive s_ready high only in IDLE and LOAD, and low in every other state.
REQ-020 SHALL register every output, so imem_we/addr/wd for a transfer appear the cycle after that transfer, with imem_we high for exactly 1 cycle.
REQ-021 SHALL write the first word after entry to IDLE at byte address 0 and each later word at the previous address plus 4.
REQ-022 SHALL move from IDLE to LOAD on the first transfer, or directly to HOLD if that transfer has s_last high.
REQ-023 SHALL move from LOAD to HOLD on the transfer that has s_last high.
REQ-024 SHALL move to ERR on a transfer that would be word number DEPTH+1, and SHALL NOT write that word.
REQ-025 SHALL make DEPTH words followed by s_last on word DEPTH a legal load.
REQ-026 SHALL keep pe_rst high for exactly RST_HOLD cycles in HOLD, then enter RUN.
REQ-027 SHALL drive pe_rst low and done high only in RUN.
REQ-028 SHALL, on reload in RUN or ERR, return to IDLE on the next cycle with pe_rst high, done/error low and the word counter cleared.
REQ-029 SHALL ignore reload in IDLE, LOAD and HOLD.
REQ-030 SHALL keep error high in ERR with pe_rst held high.
REQ-031 SHALL ignore s_valid while s_ready is low, with no write and no count.

Reset
REQ-032 SHALL, while rst is high, asynchronously force state IDLE, pe_rst=1, imem_we=0, imem_addr=0, imem_wd=0, words_loaded=0, done=0 and error=0.
REQ-033 SHALL abandon a load in progress when reset arrives mid-load, with no write issued after reset.

Configuration
REQ-034 SHALL, with LOADER_CHECKSUM_EN defined, treat the s_last word as a checksum that is not written to memory and is compared with the modulo-2^32 sum of all program words.
REQ-035 SHALL, with LOADER_CHECKSUM_EN defined, move from LOAD to HOLD on a checksum match and to ERR on a mismatch.
REQ-036 SHALL, without LOADER_CHECKSUM_EN, write the s_last word as a program word and include no checksum logic.

Structure
REQ-037 SHALL take the state encoding and the byte-per-word constant (4) from the shared package Processing_Element_pkg.
REQ-038 SHALL be a single module with no sub-modules; the RST_HOLD counter stays inline.

Verification
REQ-039 SHALL cover: 3 words 0x00500093, 0x00A00113, 0x002081B3 with s_last on word 3 -> writes to addresses 0, 4, 8; pe_rst falls 4 cycles after entering HOLD; done=1; words_loaded=3.
REQ-040 SHALL cover: s_valid toggled every other cycle -> writes are not duplicated and addresses stay contiguous.
REQ-041 SHALL cover: ADDR_WIDTH=2 with 5 words -> 4 writes, error=1, pe_rst stays 1; then reload -> IDLE with error=0.
REQ-042 SHALL cover: rst pulsed after word 2 of 4 -> no further imem_we, state IDLE, next load starts at address 0.
REQ-043 SHALL cover, with LOADER_CHECKSUM_EN: words 1 and 2 plus checksum 3 -> done=1, 2 writes; checksum 4 -> error=1.
REQ-044 SHALL cover: reload asserted during LOAD -> ignored and the load completes normally.

Source files
------------

// File: rtl/processing_element_pkg.sv
// Shared definitions for the processing-element program loader: FSM encoding
// and instruction-word geometry.
package Processing_Element_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_HOLD = 3'd2,
    ST_RUN  = 3'd3,
    ST_ERR  = 3'd4
  } state_t;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned WORD_W         = 32;

endpackage

// File: rtl/program_loader.sv
// Streams a program from a valid/ready host into instruction memory, then
// holds the processing element in reset for RST_HOLD cycles before releasing it.
// Optional build macro LOADER_CHECKSUM_EN: the s_last word becomes a checksum.
module program_loader
  import Processing_Element_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned RST_HOLD   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  input  logic [31:0]           s_data,
  input  logic                  s_last,
  output logic                  s_ready,
  input  logic                  reload,
  output logic                  imem_we,
  output logic [31:0]           imem_addr,
  output logic [31:0]           imem_wd,
  output logic                  pe_rst,
  output logic [ADDR_WIDTH:0]   words_loaded,
  output logic                  done,
  output logic                  error
);

  localparam int unsigned DEPTH  = 1 << ADDR_WIDTH;
  localparam int unsigned CNT_W  = ADDR_WIDTH + 1;
  localparam int unsigned HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

  localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);

  state_t              state, state_nx;
  logic [CNT_W-1:0]    cnt_nx;
  logic [HOLD_W-1:0]   hold_cnt, hold_nx;
  logic                we_nx;
  logic [WORD_W-1:0]   addr_nx, wd_nx;
  logic                xfer;
`ifdef LOADER_CHECKSUM_EN
  logic [WORD_W-1:0]   sum, sum_nx;
`endif

  assign xfer = s_valid && s_ready;

  // Next-state and next-output logic; everything lands in registers below.
  always_comb begin
    state_nx = state;
    cnt_nx   = words_loaded;
    hold_nx  = hold_cnt;
    we_nx    = 1'b0;
    addr_nx  = imem_addr;
    wd_nx    = imem_wd;
`ifdef LOADER_CHECKSUM_EN
    sum_nx   = sum;
`endif

    case (state)
      ST_IDLE, ST_LOAD: begin
        hold_nx = '0;
        if (xfer) begin
`ifdef LOADER_CHECKSUM_EN
          if (s_last) begin
            state_nx = (s_data == sum) ? ST_HOLD : ST_ERR;
          end else if (words_loaded == DEPTH_CNT) begin
            state_nx = ST_ERR;
          end else begin
            we_nx    = 1'b1;
            addr_nx  = WORD_W'(words_loaded) * WORD_W'(BYTES_PER_WORD);
            wd_nx    = s_data;
            cnt_nx   = words_loaded + CNT_W'(1);
            sum_nx   = sum + s_data;
            state_nx = ST_LOAD;
          end
`else
          if (words_loaded == DEPTH_CNT) begin
            state_nx = ST_ERR;
          end else begin
            we_nx    = 1'b1;
            addr_nx  = WORD_W'(words_loaded) * WORD_W'(BYTES_PER_WORD);
            wd_nx    = s_data;
            cnt_nx   = words_loaded + CNT_W'(1);
            state_nx = s_last ? ST_HOLD : ST_LOAD;
          end
`endif
        end
      end

      ST_HOLD: begin
        if (hold_cnt == HOLD_LAST) begin
          state_nx = ST_RUN;
        end else begin
          hold_nx = hold_cnt + HOLD_W'(1);
        end
      end

      ST_RUN, ST_ERR: begin
        if (reload) begin
          state_nx = ST_IDLE;
          cnt_nx   = '0;
`ifdef LOADER_CHECKSUM_EN
          sum_nx   = '0;
`endif
        end
      end

      default: state_nx = ST_IDLE;
    endcase
  end

  // State and output registers; status flags decode the upcoming state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      s_ready      <= 1'b1;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wd      <= '0;
      words_loaded <= '0;
      hold_cnt     <= '0;
      pe_rst       <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum          <= '0;
`endif
    end else begin
      state        <= state_nx;
      s_ready      <= (state_nx == ST_IDLE) || (state_nx == ST_LOAD);
      imem_we      <= we_nx;
      imem_addr    <= addr_nx;
      imem_wd      <= wd_nx;
      words_loaded <= cnt_nx;
      hold_cnt     <= hold_nx;
      pe_rst       <= (state_nx != ST_RUN);
      done         <= (state_nx == ST_RUN);
      error        <= (state_nx == ST_ERR);
`ifdef LOADER_CHECKSUM_EN
      sum          <= sum_nx;
`endif
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader (small memory, DEPTH = 4), checked
// against a list-level model of what each load should write and how it ends.
module tb_program_loader;

  localparam int unsigned AW    = 2;
  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned HOLD  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_valid;
  logic [31:0]   s_data;
  logic          s_last;
  logic          s_ready;
  logic          reload;
  logic          imem_we;
  logic [31:0]   imem_addr;
  logic [31:0]   imem_wd;
  logic          pe_rst;
  logic [AW:0]   words_loaded;
  logic          done;
  logic          error;

  int checks = 0;
  int errors = 0;

  logic [31:0] cap_addr[$];
  logic [31:0] cap_data[$];
  logic [31:0] stim[$];
  logic [31:0] exp_data[$];
  bit          exp_err;
  int          exp_loaded;

  program_loader #(.ADDR_WIDTH(AW), .RST_HOLD(HOLD)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
    .s_ready(s_ready), .reload(reload), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wd(imem_wd), .pe_rst(pe_rst), .words_loaded(words_loaded),
    .done(done), .error(error)
  );

  always #5 clk = ~clk;

  // Record every memory write just after the edge that produced it.
  always @(posedge clk) begin
    #1;
    if (imem_we === 1'b1) begin
      cap_addr.push_back(imem_addr);
      cap_data.push_back(imem_wd);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Expected writes/outcome from the word list: program words, overflow, checksum.
  task automatic build_expected();
    logic [31:0] prog[$];
    logic [31:0] acc;
    exp_data.delete();
`ifdef LOADER_CHECKSUM_EN
    for (int i = 0; i < stim.size() - 1; i++) prog.push_back(stim[i]);
`else
    for (int i = 0; i < stim.size(); i++) prog.push_back(stim[i]);
`endif
    if (prog.size() > DEPTH) begin
      for (int i = 0; i < DEPTH; i++) exp_data.push_back(prog[i]);
      exp_err    = 1'b1;
      exp_loaded = DEPTH;
    end else begin
      exp_data   = prog;
      exp_loaded = prog.size();
      acc = 32'h0;
      foreach (prog[i]) acc = acc + prog[i];
`ifdef LOADER_CHECKSUM_EN
      exp_err = (acc != stim[stim.size() - 1]);
`else
      exp_err = 1'b0;
`endif
    end
  endtask

  task automatic send_all(input int gap_mode, input int reload_at);
    bit accepted;
    bit rdy;
    int tries;
    for (int i = 0; i < stim.size(); i++) begin
      if ((gap_mode == 1 && i > 0) || (gap_mode == 2 && $urandom_range(1, 0) == 1)) begin
        @(negedge clk);
        s_valid = 1'b0; s_data = $urandom; s_last = 1'($urandom); reload = 1'b0;
        @(posedge clk);
      end
      accepted = 1'b0;
      tries = 0;
      while (!accepted && tries < 6) begin
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = stim[i];
        s_last  = (i == stim.size() - 1);
        reload  = (i == reload_at) && (tries == 0);
        rdy     = s_ready;
        @(posedge clk);
        accepted = rdy;
        tries++;
      end
      if (!accepted) break;
    end
  endtask

  task automatic check_outcome(input string name);
    int cycles;
    if (exp_err) begin
      repeat (4) begin
        @(negedge clk);
        s_valid = 1'($urandom); s_data = $urandom; s_last = 1'($urandom); reload = 1'b0;
      end
      if (error !== 1'b1) begin errors++; $display("FAIL %s_error: got %b expected 1", name, error); end
      checks++;
      if (pe_rst !== 1'b1) begin errors++; $display("FAIL %s_pe_rst_err: got %b expected 1", name, pe_rst); end
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL %s_done_err: got %b expected 0", name, done); end
      checks++;
    end else begin
      cycles = 0;
      while (cycles < 20) begin
        @(negedge clk);
        s_valid = 1'($urandom); s_data = $urandom; s_last = 1'($urandom); reload = 1'b0;
        if (pe_rst === 1'b0) break;
        @(posedge clk);
        cycles++;
      end
      if (cycles != HOLD) begin errors++; $display("FAIL %s_hold_cycles: got %0d expected %0d", name, cycles, HOLD); end
      checks++;
      repeat (3) begin
        @(negedge clk);
        s_valid = 1'($urandom); s_data = $urandom; s_last = 1'($urandom);
      end
      if (done !== 1'b1) begin errors++; $display("FAIL %s_done: got %b expected 1", name, done); end
      checks++;
      if (error !== 1'b0) begin errors++; $display("FAIL %s_error_run: got %b expected 0", name, error); end
      checks++;
    end
    if (s_ready !== 1'b0) begin errors++; $display("FAIL %s_ready_low: got %b expected 0", name, s_ready); end
    checks++;
    if (int'(words_loaded) != exp_loaded) begin
      errors++; $display("FAIL %s_words_loaded: got %0d expected %0d", name, words_loaded, exp_loaded);
    end
    checks++;
    if (cap_addr.size() != exp_data.size()) begin
      errors++; $display("FAIL %s_nwrites: got %0d expected %0d", name, cap_addr.size(), exp_data.size());
    end
    checks++;
    for (int i = 0; i < cap_addr.size() && i < exp_data.size(); i++) begin
      if (cap_addr[i] !== 32'(i * 4) || cap_data[i] !== exp_data[i]) begin
        errors++;
        $display("FAIL %s_write%0d: got addr %0h data %0h expected addr %0h data %0h",
                 name, i, cap_addr[i], cap_data[i], 32'(i * 4), exp_data[i]);
      end
      checks++;
    end
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic do_reload(input string name);
    @(negedge clk);
    s_valid = 1'b0; reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    if (pe_rst !== 1'b1 || done !== 1'b0 || error !== 1'b0 || words_loaded !== '0 || s_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_reload: got pe_rst %b done %b error %b words %0d ready %b expected 1 0 0 0 1",
               name, pe_rst, done, error, words_loaded, s_ready);
    end
    checks++;
  endtask

  task automatic run_load(input string name, input int gap_mode, input int reload_at);
    cap_addr.delete();
    cap_data.delete();
    build_expected();
    send_all(gap_mode, reload_at);
    check_outcome(name);
    do_reload(name);
  endtask

  task automatic test_reset();
    rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; reload = 1'b0;
    repeat (2) @(negedge clk);
    if (pe_rst !== 1'b1 || imem_we !== 1'b0 || imem_addr !== '0 || imem_wd !== '0 ||
        words_loaded !== '0 || done !== 1'b0 || error !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: got pe_rst %b we %b addr %0h wd %0h words %0d done %b error %b",
               pe_rst, imem_we, imem_addr, imem_wd, words_loaded, done, error);
    end
    checks++;
    rst = 1'b0;
    @(negedge clk);
    if (s_ready !== 1'b1 || pe_rst !== 1'b1) begin
      errors++; $display("FAIL reset_idle: got ready %b pe_rst %b expected 1 1", s_ready, pe_rst);
    end
    checks++;
  endtask

  task automatic test_basic();
    stim = '{32'h00500093, 32'h00A00113, 32'h002081B3};
    run_load("basic", 0, -1);
  endtask

  task automatic test_gapped();
    stim.delete();
    repeat (4) stim.push_back($urandom);
    run_load("gapped", 1, -1);
  endtask

  task automatic test_full();
    logic [31:0] acc;
    stim.delete();
    acc = 32'h0;
    repeat (DEPTH) begin
      stim.push_back($urandom);
      acc = acc + stim[stim.size() - 1];
    end
`ifdef LOADER_CHECKSUM_EN
    stim.push_back(acc);
`endif
    run_load("full", 0, -1);
  endtask

  task automatic test_overflow();
    stim.delete();
    repeat (DEPTH + 1) stim.push_back($urandom);
    run_load("overflow", 0, -1);
  endtask

  task automatic test_reset_mid();
    cap_addr.delete();
    cap_data.delete();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      s_valid = 1'b1; s_data = $urandom; s_last = 1'b0;
      @(posedge clk);
    end
    @(negedge clk);
    rst = 1'b1; s_valid = 1'b0;
    #1;
    if (imem_we !== 1'b0 || pe_rst !== 1'b1 || words_loaded !== '0) begin
      errors++; $display("FAIL midrst_async: got we %b pe_rst %b words %0d expected 0 1 0", imem_we, pe_rst, words_loaded);
    end
    checks++;
    if (cap_addr.size() != 2) begin
      errors++; $display("FAIL midrst_prewrites: got %0d expected 2", cap_addr.size());
    end
    checks++;
    cap_addr.delete();
    cap_data.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    if (cap_addr.size() != 0 || s_ready !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL midrst_idle: got writes %0d ready %b done %b expected 0 1 0", cap_addr.size(), s_ready, done);
    end
    checks++;
    stim.delete();
    repeat (4) stim.push_back($urandom);
    run_load("after_rst", 0, -1);
  endtask

  task automatic test_checksum();
    stim = '{32'd1, 32'd2, 32'd3};
    run_load("cksum_ok", 0, -1);
    stim = '{32'd1, 32'd2, 32'd4};
    run_load("cksum_bad", 0, -1);
  endtask

  task automatic test_reload_in_load();
    stim.delete();
    repeat (4) stim.push_back($urandom);
    run_load("reload_ignored", 0, 2);
  endtask

  task automatic test_back_to_back();
    int len;
    logic [31:0] acc;
    for (int n = 0; n < 8; n++) begin
      len = $urandom_range(DEPTH + 2, 1);
      stim.delete();
      acc = 32'h0;
      for (int i = 0; i < len - 1; i++) begin
        stim.push_back($urandom);
        acc = acc + stim[i];
      end
      stim.push_back(($urandom_range(1, 0) == 1) ? acc : 32'($urandom));
      run_load("b2b", 2, -1);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gapped();
    test_full();
    test_overflow();
    test_reset_mid();
    test_checksum();
    test_reload_in_load();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
